nonce_reporter: RTL and testbench
=================================

NONCE_REPORTER -- requirements
Module: nonce_reporter

Interface
REQ-001 Parameter: HEADER, 8'hA5, first byte of every report frame.
REQ-002 Parameter: DUP_CNT_W, 8, width of the duplicate-success counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 newblock_i  input  1  one-cycle pulse; a new block search starts.
REQ-006 valid_i  input  1  decoder result qualifier (from nonce_decoder valid_o).
REQ-007 success_i  input  1  decoder found a nonce (from nonce_decoder success_o).
REQ-008 nonce_i  input  32  winning nonce (from nonce_decoder nonce_o).
REQ-009 out_valid_o  output  1  byte-stream valid.
REQ-010 out_data_o  output  8  byte-stream data.
REQ-011 out_ready_i  input  1  byte-stream ready from host link.
REQ-012 busy_o  output  1  frame transmitting or pending.
REQ-013 dup_cnt_o  output  DUP_CNT_W  saturating count of suppressed successes in the current block.

Function
REQ-014 A hit is a cycle with valid_i=1 and success_i=1 and newblock_i=0.
REQ-015 Only the first hit after each newblock_i is reported; later hits in the same block increment dup_cnt_o, saturating at all-ones.
REQ-016 A hit in the same cycle as newblock_i is discarded: no report, no count.
REQ-017 newblock_i clears the per-block reported flag and dup_cnt_o to 0 on the next edge.
REQ-018 Frame = 5 bytes: HEADER, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0].
REQ-019 A byte transfers on a rising edge where out_valid_o=1 and out_ready_i=1.
REQ-020 While out_valid_o=1 and out_ready_i=0, out_valid_o and out_data_o hold stable.
REQ-021 FSM states: IDLE, SEND; byte index 0..4 in SEND.
REQ-022 IDLE -> SEND on the edge capturing a hit (or on the edge after a frame ends if pending set); out_valid_o=1 with HEADER in the following cycle (latency 1).
REQ-023 SEND index increments per transfer; transfer at index 4 returns to IDLE, or restarts SEND at index 0 if pending set.
REQ-024 Minimum frame duration with out_ready_i held 1: 5 cycles; no idle gap between back-to-back frames.
REQ-025 One-deep pending register: a hit arriving while in SEND latches its nonce into pending.
REQ-026 newblock_i in SEND with index 0 and no byte yet transferred aborts the frame: out_valid_o drops next cycle, FSM to IDLE.
REQ-027 newblock_i after the first byte of a frame has transferred does not abort; the frame completes.
REQ-028 newblock_i clears pending; pending therefore never overflows.
REQ-029 busy_o = (state==SEND) or pending.
REQ-030 Nonce is captured at the hit edge; later changes of nonce_i do not affect the frame.

Reset
REQ-031 rst asserted: state=IDLE, index=0, pending=0, reported=0, out_valid_o=0, out_data_o=0, busy_o=0, dup_cnt_o=0, immediately (asynchronously).
REQ-032 rst mid-frame discards the frame; first cycle after deassertion behaves as after newblock_i with no hit.

Structure
REQ-033 Package nonce_report_pkg holds the FSM state enum, FRAME_LEN=5, and the HEADER default constant.
REQ-034 One sub-module, nonce_frame_serializer: 32-bit nonce load, valid/ready byte output, done pulse; nonce_reporter holds block/pending/dup logic.

Verification
REQ-035 rst, newblock_i, hit nonce 32'h12345678, out_ready_i=1 -> bytes A5,12,34,56,78 on 5 consecutive cycles starting 1 cycle after hit, busy_o low after.
REQ-036 Same hit, out_ready_i low 3 cycles after HEADER presented -> A5 held stable 3 cycles, then frame completes unchanged.
REQ-037 Hits 32'h1, 32'h2, 32'h3 in one block -> only frame for 32'h1; dup_cnt_o=2; newblock_i -> dup_cnt_o=0.
REQ-038 newblock_i and hit same cycle -> no frame; dup_cnt_o stays 0.
REQ-039 out_ready_i=0, hit 32'hAAAA0000, newblock_i before first transfer -> frame aborted, out_valid_o low; hit 32'hBBBB0000 after newblock_i mid-frame -> first frame completes, BBBB frame follows with no gap.
REQ-040 rst asserted during byte 2 -> out_valid_o=0 immediately, no residual bytes after release.

Source files
------------

// File: rtl/nonce_report_pkg.sv
// Shared types and constants for the nonce report path: serializer FSM
// states, frame geometry, default header byte and a byte-select helper.
package nonce_report_pkg;

  // Serializer is either waiting for a nonce or walking through a frame.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } serState_e;

  // One report frame is the header byte followed by the four nonce bytes.
  localparam int FRAME_LEN = 5;
  localparam int IDX_W     = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  // Default first byte of every frame; the host uses it to resynchronise.
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Byte presented at a given frame position, nonce sent most significant first.
  function automatic logic [7:0] frameByte(input logic [7:0]       hdr,
                                           input logic [31:0]      nonce,
                                           input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = hdr;
      3'd1:    b = nonce[31:24];
      3'd2:    b = nonce[23:16];
      3'd3:    b = nonce[15:8];
      3'd4:    b = nonce[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nonce_frame_serializer.sv
// Turns a loaded 32-bit nonce into a five-byte valid/ready stream
// (header first). A load is only honoured while idle or on the edge of the
// final transfer, which lets frames run back to back without a gap. An abort
// request cancels a frame whose header has not yet been accepted.
module nonce_frame_serializer
  import nonce_report_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] nonce_i,
  input  logic        abort_i,
  input  logic        out_ready_i,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o,
  output logic        sending_o,
  output logic        done_o
);

  serState_e        state_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      nonce_q;
  logic             outValid_q;
  logic [7:0]       outData_q;

  logic xfer;
  logic lastXfer;
  logic abortNow;

  // Handshake decode: a byte moves whenever we are sending and the host is ready.
  always_comb begin
    xfer     = (state_q == SEND) && out_ready_i;
    lastXfer = xfer && (idx_q == LAST_IDX);
    abortNow = abort_i && (state_q == SEND) && (idx_q == '0) && !out_ready_i;
  end

  // Frame FSM with registered stream outputs; data only changes after a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      nonce_q    <= '0;
      outValid_q <= 1'b0;
      outData_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_i) begin
            state_q    <= SEND;
            idx_q      <= '0;
            nonce_q    <= nonce_i;
            outValid_q <= 1'b1;
            outData_q  <= HEADER;
          end
        end
        SEND: begin
          if (abortNow) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            outValid_q <= 1'b0;
            outData_q  <= 8'h00;
          end else if (lastXfer) begin
            if (load_i) begin
              idx_q      <= '0;
              nonce_q    <= nonce_i;
              outValid_q <= 1'b1;
              outData_q  <= HEADER;
            end else begin
              state_q    <= IDLE;
              idx_q      <= '0;
              outValid_q <= 1'b0;
              outData_q  <= 8'h00;
            end
          end else if (xfer) begin
            idx_q     <= idx_q + IDX_W'(1);
            outData_q <= frameByte(HEADER, nonce_q, idx_q + IDX_W'(1));
          end
        end
        default: begin
          state_q    <= IDLE;
          idx_q      <= '0;
          outValid_q <= 1'b0;
          outData_q  <= 8'h00;
        end
      endcase
    end
  end

  assign out_valid_o = outValid_q;
  assign out_data_o  = outData_q;
  assign sending_o   = (state_q == SEND);
  assign done_o      = lastXfer;

endmodule

// File: rtl/nonce_reporter.sv
// Reports the first winning nonce of each block search to the host as a
// five-byte frame. Later wins in the same block are only counted. A single
// pending slot holds a winner that arrives while an older frame is still
// going out, and a new block cancels anything not yet started.
module nonce_reporter
  import nonce_report_pkg::*;
#(
  parameter logic [7:0] HEADER    = HEADER_DEFAULT,
  parameter int         DUP_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 newblock_i,
  input  logic                 valid_i,
  input  logic                 success_i,
  input  logic [31:0]          nonce_i,
  output logic                 out_valid_o,
  output logic [7:0]           out_data_o,
  input  logic                 out_ready_i,
  output logic                 busy_o,
  output logic [DUP_CNT_W-1:0] dup_cnt_o
);

  logic                 reported_q, reported_d;
  logic                 pendValid_q, pendValid_d;
  logic [31:0]          pendNonce_q, pendNonce_d;
  logic [DUP_CNT_W-1:0] dupCnt_q, dupCnt_d;

  logic        hit;
  logic        newReport;
  logic        serSending;
  logic        serDone;
  logic        serReady;
  logic        loadPend;
  logic        loadHit;
  logic        serLoad;
  logic [31:0] serNonce;

  // Decide whether this cycle produces a frame now, later, or not at all.
  always_comb begin
    hit       = valid_i && success_i && !newblock_i;
    newReport = hit && !reported_q;
    serReady  = !serSending || serDone;
    loadPend  = pendValid_q && serReady && !newblock_i;
    loadHit   = newReport && serReady && !pendValid_q;
    serLoad   = loadPend || loadHit;
    serNonce  = pendValid_q ? pendNonce_q : nonce_i;
  end

  // Per-block bookkeeping: reported flag, pending slot and duplicate counter.
  always_comb begin
    reported_d  = reported_q;
    pendValid_d = pendValid_q;
    pendNonce_d = pendNonce_q;
    dupCnt_d    = dupCnt_q;
    if (newblock_i) begin
      reported_d  = 1'b0;
      pendValid_d = 1'b0;
      dupCnt_d    = '0;
    end else begin
      if (hit) begin
        if (reported_q) begin
          if (dupCnt_q != '1) begin
            dupCnt_d = dupCnt_q + DUP_CNT_W'(1);
          end
        end else begin
          reported_d = 1'b1;
        end
      end
      if (loadPend) begin
        pendValid_d = 1'b0;
      end else if (newReport && !loadHit) begin
        pendValid_d = 1'b1;
        pendNonce_d = nonce_i;
      end
    end
  end

  // Bookkeeping registers; reset behaves like the start of an empty block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reported_q  <= 1'b0;
      pendValid_q <= 1'b0;
      pendNonce_q <= '0;
      dupCnt_q    <= '0;
    end else begin
      reported_q  <= reported_d;
      pendValid_q <= pendValid_d;
      pendNonce_q <= pendNonce_d;
      dupCnt_q    <= dupCnt_d;
    end
  end

  nonce_frame_serializer #(
    .HEADER(HEADER)
  ) u_serializer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (serLoad),
    .nonce_i    (serNonce),
    .abort_i    (newblock_i),
    .out_ready_i(out_ready_i),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .sending_o  (serSending),
    .done_o     (serDone)
  );

  assign busy_o    = serSending || pendValid_q;
  assign dup_cnt_o = dupCnt_q;

endmodule

// File: tb/tb_nonce_reporter.sv
// Scoreboard bench for nonce_reporter: the driver updates a frame-level
// reference model and queues expected bytes; a negedge monitor compares
// every transferred byte plus valid, busy and duplicate count each cycle.
module tb_nonce_reporter;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int DW = 8;
  localparam int DUP_MAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          newblock_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          success_i = 1'b0;
  logic [31:0]   nonce_i = '0;
  logic          out_ready_i = 1'b0;
  logic          out_valid_o;
  logic [7:0]    out_data_o;
  logic          busy_o;
  logic [DW-1:0] dup_cnt_o;

  always #5 clk = ~clk;

  nonce_reporter #(
    .HEADER(HDR),
    .DUP_CNT_W(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .newblock_i (newblock_i),
    .valid_i    (valid_i),
    .success_i  (success_i),
    .nonce_i    (nonce_i),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_ready_i(out_ready_i),
    .busy_o     (busy_o),
    .dup_cnt_o  (dup_cnt_o)
  );

  int checksTotal = 0;
  int checksPassed = 0;

  // Reference model: frame-level view of the reporter.
  logic [7:0]  expQ[$];
  logic [31:0] mPend[$];
  bit          mReported;
  int          mDup;
  int          mLeft;
  int          mSent;
  bit          checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic modelReset();
    expQ.delete();
    mPend.delete();
    mReported = 1'b0;
    mDup = 0;
    mLeft = 0;
    mSent = 0;
  endtask

  task automatic startFrame(input logic [31:0] n);
    expQ.push_back(HDR);
    expQ.push_back(n[31:24]);
    expQ.push_back(n[23:16]);
    expQ.push_back(n[15:8]);
    expQ.push_back(n[7:0]);
    mLeft = 5;
    mSent = 0;
  endtask

  // Advance the model by one clock edge given the inputs held during that cycle.
  task automatic modelStep(input bit nb, input bit v, input bit s, input logic [31:0] n, input bit rdy);
    bit hit, active, xfer, last, abortF, free, newRep;
    hit    = v && s && !nb;
    active = (mLeft > 0);
    xfer   = active && rdy;
    last   = xfer && (mLeft == 1);
    abortF = nb && active && (mSent == 0) && !rdy;
    free   = !active || last;
    newRep = hit && !mReported;
    if (xfer) begin
      mLeft--;
      mSent++;
    end
    if (abortF) begin
      repeat (5) if (expQ.size() > 0) void'(expQ.pop_back());
      mLeft = 0;
    end
    if (nb) begin
      mReported = 1'b0;
      mDup = 0;
      mPend.delete();
    end else if (hit) begin
      if (mReported) begin
        if (mDup < DUP_MAX) mDup++;
      end else begin
        mReported = 1'b1;
      end
    end
    if (newRep) mPend.push_back(n);
    if (free && !abortF && mPend.size() > 0) startFrame(mPend.pop_front());
  endtask

  // Drive one cycle of inputs, let the edge pass, then update the model.
  task automatic applyStimulus(input bit nb, input bit v, input bit s, input logic [31:0] n, input bit rdy);
    newblock_i  = nb;
    valid_i     = v;
    success_i   = s;
    nonce_i     = n;
    out_ready_i = rdy;
    @(posedge clk);
    #2;
    modelStep(nb, v, s, n, rdy);
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_valid", out_valid_o, 0);
    checkOutput("rst_data", out_data_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_dup", dup_cnt_o, 0);
    modelReset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: compare cycle-level status and pop one expected byte per transfer.
  bit         prevHeld = 1'b0;
  logic [7:0] prevData = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      if (rst || !checkEn) begin
        prevHeld = 1'b0;
      end else begin
        checkOutput("out_valid", out_valid_o, (mLeft > 0));
        checkOutput("busy", busy_o, ((mLeft > 0) || (mPend.size() > 0)));
        checkOutput("dup_cnt", dup_cnt_o, mDup);
        if (prevHeld && out_valid_o) checkOutput("hold_data", out_data_o, prevData);
        if (out_valid_o && out_ready_i) begin
          checkOutput("byte_expected", (expQ.size() > 0), 1);
          if (expQ.size() > 0) checkOutput("byte_data", out_data_o, expQ.pop_front());
        end
        prevHeld = out_valid_o && !out_ready_i;
        prevData = out_data_o;
      end
    end
  end

  logic [7:0] seq035[5];

  initial begin
    modelReset();
    #1;
    checkOutput("init_valid", out_valid_o, 0);
    checkOutput("init_busy", busy_o, 0);
    checkOutput("init_dup", dup_cnt_o, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    checkEn = 1'b1;

    // Single frame, host always ready.
    seq035[0] = 8'hA5; seq035[1] = 8'h12; seq035[2] = 8'h34;
    seq035[3] = 8'h56; seq035[4] = 8'h78;
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 32'h12345678, 1);
    checkOutput("t035_first_valid", out_valid_o, 1);
    checkOutput("t035_byte0", out_data_o, seq035[0]);
    for (int i = 1; i < 5; i++) begin
      applyStimulus(0, 0, 0, $urandom, 1);
      checkOutput($sformatf("t035_byte%0d", i), out_data_o, seq035[i]);
    end
    applyStimulus(0, 0, 0, $urandom, 1);
    checkOutput("t035_end_valid", out_valid_o, 0);
    checkOutput("t035_end_busy", busy_o, 0);

    // Backpressure on the header.
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 32'h12345678, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, $urandom, 0);
      checkOutput("t036_hold_hdr", out_data_o, 8'hA5);
    end
    repeat (5) applyStimulus(0, 0, 0, $urandom, 1);
    checkOutput("t036_end_valid", out_valid_o, 0);

    // Duplicate hits in one block.
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 32'h1, 1);
    applyStimulus(0, 1, 1, 32'h2, 1);
    applyStimulus(0, 1, 1, 32'h3, 1);
    checkOutput("t037_dup2", dup_cnt_o, 2);
    repeat (4) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("t037_dup_clr", dup_cnt_o, 0);

    // Hit coinciding with newblock is dropped.
    applyStimulus(1, 1, 1, 32'hDEADBEEF, 1);
    checkOutput("t038_valid", out_valid_o, 0);
    checkOutput("t038_dup", dup_cnt_o, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t038_valid_later", out_valid_o, 0);

    // Abort before first transfer, then non-aborting newblock mid-frame.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 32'hAAAA0000, 0);
    checkOutput("t039_hdr", out_data_o, 8'hA5);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t039_abort_valid", out_valid_o, 0);
    checkOutput("t039_abort_busy", busy_o, 0);
    applyStimulus(0, 1, 1, 32'h11112222, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 32'hBBBB0000, 1);
    checkOutput("t039_pending_busy", busy_o, 1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      if (i == 0) checkOutput("t039_second_hdr", out_data_o, 8'hA5);
      checkOutput("t039_gapless", out_valid_o, (i < 5));
    end

    // Reset in the middle of a frame.
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 32'hCAFEF00D, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t040_byte2", out_data_o, 8'hFE);
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("t040_no_residual", out_valid_o, 0);
    end

    // Duplicate counter saturation.
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < DUP_MAX + 40; i++) applyStimulus(0, 1, 1, $urandom, 1);
    checkOutput("sat_dup", dup_cnt_o, DUP_MAX);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("sat_clr", dup_cnt_o, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) doReset();
      applyStimulus(($urandom_range(99) < 5), $urandom_range(1), ($urandom_range(99) < 30),
                    $urandom, ($urandom_range(99) < 70));
    end

    // Drain and finish.
    repeat (12) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("queue_drained", expQ.size(), 0);
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
